conv_window_ctrl: RTL and testbench



---
 rtl/conv_window_ctrl.sv | 150 +++++++++++++++
 tb/tb_conv_window_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: turns a raster pixel stream into 3x3 windows.
// Four rotating line buffers hold the incoming lines. A read phase starts
// once three complete lines are held and walks across them one column
// per cycle.
module conv_window_ctrl #(
    parameter int IMG_WIDTH = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_in_valid,
    output logic [71:0] o_pixel_values,
    output logic        o_pixel_values_valid,
    output logic        o_intr
);

    localparam int PW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [PW-1:0] LAST_COL = PW'(IMG_WIDTH - 1);
    localparam logic [PW-1:0] LAST_RD  = PW'(IMG_WIDTH - 3);

    typedef enum logic {
        IDLE,
        READ
    } stateT;

    // Line storage: deliberately not reset, so it can map onto distributed RAM
    logic [7:0]    lineBuf [4][IMG_WIDTH];

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [1:0]    wrSel_q, wrSel_d;
    logic          lineDone;

    stateT         state_q, state_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [1:0]    rdSel_q, rdSel_d;
    logic          readFire;
    logic          phaseDone;

    logic [2:0]    linesFull_q, linesFull_d;
    logic [71:0]   window;

    // Write pointer advance; a line completes when its last column is written
    always_comb begin
        wrPtr_d  = wrPtr_q;
        wrSel_d  = wrSel_q;
        lineDone = 1'b0;
        if (pixel_in_valid) begin
            if (wrPtr_q == LAST_COL) begin
                wrPtr_d  = '0;
                wrSel_d  = wrSel_q + 2'd1;
                lineDone = 1'b1;
            end else begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
        end
    end

    // Store each accepted pixel into the line currently being filled
    always_ff @(posedge clk) begin
        if (pixel_in_valid) begin
            lineBuf[wrSel_q][wrPtr_q] <= pixel_in;
        end
    end

    // Read FSM: wait for three full lines, then sweep IMG_WIDTH-2 windows
    always_comb begin
        state_d   = state_q;
        rdPtr_d   = rdPtr_q;
        rdSel_d   = rdSel_q;
        readFire  = 1'b0;
        phaseDone = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (linesFull_q >= 3'd3) begin
                    state_d = READ;
                    rdPtr_d = '0;
                end
            end
            READ: begin
                readFire = 1'b1;
                if (rdPtr_q == LAST_RD) begin
                    phaseDone = 1'b1;
                    state_d   = IDLE;
                    rdPtr_d   = '0;
                    rdSel_d   = rdSel_q + 2'd1;
                end else begin
                    rdPtr_d = rdPtr_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Count of complete, unconsumed lines; simultaneous fill and drain cancel
    always_comb begin
        linesFull_d = linesFull_q;
        if (lineDone && !phaseDone) begin
            linesFull_d = linesFull_q + 3'd1;
        end else if (!lineDone && phaseDone) begin
            linesFull_d = linesFull_q - 3'd1;
        end
    end

    // Combinational 3x3 gather: row 0 is the oldest line, col 0 the leftmost
    always_comb begin
        window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window[(r*3 + c)*8 +: 8] = lineBuf[rdSel_q + 2'(r)][rdPtr_q + PW'(c)];
            end
        end
    end

    // Control state registers; reset discards any partially written line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            wrSel_q     <= '0;
            rdPtr_q     <= '0;
            rdSel_q     <= '0;
            linesFull_q <= '0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            wrSel_q     <= wrSel_d;
            rdPtr_q     <= rdPtr_d;
            rdSel_q     <= rdSel_d;
            linesFull_q <= linesFull_d;
        end
    end

    // Output stage: window is held between phases, interrupt marks the last one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pixel_values       <= '0;
            o_pixel_values_valid <= 1'b0;
            o_intr               <= 1'b0;
        end else begin
            o_pixel_values_valid <= readFire;
            o_intr               <= phaseDone;
            if (readFire) begin
                o_pixel_values <= window;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Testbench for conv_window_ctrl with IMG_WIDTH = 8.
// The reference model keeps every completed line as a plain array. It derives
// each expected window from lines (m, m+1, m+2) at columns (c, c+1, c+2).
module tb_conv_window_ctrl;

    localparam int W   = 8;
    localparam int WPP = W - 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pixel_in = 8'h00;
    logic        pixel_in_valid = 1'b0;
    logic [71:0] o_pixel_values;
    logic        o_pixel_values_valid;
    logic        o_intr;

    int nChecks = 0;
    int nFail = 0;
    int cyc = 0;
    int strayIntr = 0;
    int maxLinesFull = 0;

    logic [W*8-1:0] lines[$];
    int             lineEndCyc[$];
    logic [71:0]    obsWin[$];
    logic           obsIntr[$];
    int             obsCyc[$];

    conv_window_ctrl #(.IMG_WIDTH(W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pixel_in            (pixel_in),
        .pixel_in_valid      (pixel_in_valid),
        .o_pixel_values      (o_pixel_values),
        .o_pixel_values_valid(o_pixel_values_valid),
        .o_intr              (o_intr)
    );

    // Free-running clock and a cycle counter for latency measurements
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every presented window on the falling edge, away from updates
    always @(negedge clk) begin
        if (!rst) begin
            if (o_pixel_values_valid) begin
                obsWin.push_back(o_pixel_values);
                obsIntr.push_back(o_intr);
                obsCyc.push_back(cyc);
            end else if (o_intr) begin
                strayIntr++;
            end
            if (int'(dut.linesFull_q) > maxLinesFull) maxLinesFull = int'(dut.linesFull_q);
        end
    end

    // Expected window for read phase 'phase', leftmost column 'col'
    function automatic logic [71:0] expWindow(input int phase, input int col);
        logic [71:0]    w;
        logic [W*8-1:0] ln;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            ln = lines[phase + r];
            for (int c = 0; c < 3; c++) begin
                w[(r*3 + c)*8 +: 8] = ln[(col + c)*8 +: 8];
            end
        end
        return w;
    endfunction

    // Pulse reset and forget all model and observation history
    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        pixel_in_valid = 1'b0;
        lines.delete();
        lineEndCyc.delete();
        obsWin.delete();
        obsIntr.delete();
        obsCyc.delete();
        strayIntr = 0;
        maxLinesFull = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Stream whole lines. mode 0: (row<<4)|col, 1: 0x80|col, 2: random.
    // gapMode 0: continuous, 1: 1-in-3 duty, 2: random 0..2 idle cycles.
    task automatic applyStimulus(input int nLines, input int mode, input int gapMode);
        for (int l = 0; l < nLines; l++) begin
            int             row;
            logic [W*8-1:0] lineBits;
            row = lines.size();
            lineBits = '0;
            for (int c = 0; c < W; c++) begin
                int         gaps;
                logic [7:0] px;
                gaps = (gapMode == 1) ? 2 : (gapMode == 2) ? int'($urandom_range(0, 2)) : 0;
                px = (mode == 0) ? 8'((row << 4) | c) :
                     (mode == 1) ? 8'(8'h80 | c) : 8'($urandom);
                for (int g = 0; g < gaps; g++) begin
                    @(negedge clk);
                    pixel_in_valid = 1'b0;
                    pixel_in = 8'($urandom);
                end
                @(negedge clk);
                pixel_in = px;
                pixel_in_valid = 1'b1;
                lineBits[c*8 +: 8] = px;
                if (c == W - 1) lineEndCyc.push_back(cyc);
            end
            lines.push_back(lineBits);
        end
        @(negedge clk);
        pixel_in_valid = 1'b0;
    endtask

    // Bounded wait for n windows, then linger so surplus windows would show up
    task automatic waitWindows(input int n, input int budget);
        int t;
        t = 0;
        while (obsWin.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        pixel_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        nChecks++;
        if (o_pixel_values_valid !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL reset valid: got %b expected 0", o_pixel_values_valid);
        end
        nChecks++;
        if (o_intr !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL reset intr: got %b expected 0", o_intr);
        end
        nChecks++;
        if (o_pixel_values !== 72'h0) begin
            nFail++;
            $display("[TB] FAIL reset values: got %h expected 0", o_pixel_values);
        end
        obsWin.delete();
        obsIntr.delete();
        obsCyc.delete();
        lines.delete();
        lineEndCyc.delete();
        strayIntr = 0;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pixel_in = 8'($urandom);
        end
        nChecks++;
        if (obsWin.size() != 0) begin
            nFail++;
            $display("[TB] FAIL idle windows: got %0d expected 0", obsWin.size());
        end
        nChecks++;
        if (strayIntr != 0 || o_intr !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL idle intr: got %0d/%b expected 0/0", strayIntr, o_intr);
        end
        nChecks++;
        if (o_pixel_values !== 72'h0) begin
            nFail++;
            $display("[TB] FAIL idle values: got %h expected 0", o_pixel_values);
        end
    endtask

    task automatic test_first_window();
        resetDut();
        applyStimulus(3, 0, 0);
        waitWindows(WPP, 200);
        nChecks++;
        if (obsWin.size() != WPP) begin
            nFail++;
            $display("[TB] FAIL firstWin count: got %0d expected %0d", obsWin.size(), WPP);
        end
        if (obsWin.size() >= WPP) begin
            logic [71:0] w0;
            logic [71:0] w5;
            w0 = obsWin[0];
            w5 = obsWin[WPP-1];
            nChecks++;
            if (obsCyc[0] != lineEndCyc[2] + 3) begin
                nFail++;
                $display("[TB] FAIL firstWin latency: got cycle %0d expected %0d", obsCyc[0], lineEndCyc[2] + 3);
            end
            nChecks++;
            if ({w0[71:64], w0[31:24], w0[23:16], w0[7:0]} !== 32'h22_10_02_00) begin
                nFail++;
                $display("[TB] FAIL firstWin bytes: got %h expected 22100200",
                         {w0[71:64], w0[31:24], w0[23:16], w0[7:0]});
            end
            nChecks++;
            if ({w5[71:64], w5[7:0]} !== 16'h27_05) begin
                nFail++;
                $display("[TB] FAIL sixthWin bytes: got %h expected 2705", {w5[71:64], w5[7:0]});
            end
            for (int i = 0; i < WPP; i++) begin
                logic expI;
                expI = (i == WPP - 1);
                nChecks++;
                if (obsWin[i] !== expWindow(0, i)) begin
                    nFail++;
                    $display("[TB] FAIL firstWin[%0d]: got %h expected %h", i, obsWin[i], expWindow(0, i));
                end
                nChecks++;
                if (obsIntr[i] !== expI) begin
                    nFail++;
                    $display("[TB] FAIL firstWin intr[%0d]: got %b expected %b", i, obsIntr[i], expI);
                end
                if (i > 0) begin
                    nChecks++;
                    if (obsCyc[i] != obsCyc[i-1] + 1) begin
                        nFail++;
                        $display("[TB] FAIL firstWin gap[%0d]: got cycle %0d expected %0d", i, obsCyc[i], obsCyc[i-1] + 1);
                    end
                end
            end
        end
        nChecks++;
        if (strayIntr != 0) begin
            nFail++;
            $display("[TB] FAIL firstWin stray intr: got %0d expected 0", strayIntr);
        end
    endtask

    task automatic test_steady_stream();
        int nExp;
        resetDut();
        applyStimulus(10, 0, 0);
        nExp = 8 * WPP;
        waitWindows(nExp, 400);
        nChecks++;
        if (obsWin.size() != nExp) begin
            nFail++;
            $display("[TB] FAIL steady count: got %0d expected %0d", obsWin.size(), nExp);
        end
        for (int i = 0; i < nExp && i < obsWin.size(); i++) begin
            logic expI;
            expI = ((i % WPP) == WPP - 1);
            nChecks++;
            if (obsWin[i] !== expWindow(i / WPP, i % WPP)) begin
                nFail++;
                $display("[TB] FAIL steady win[%0d]: got %h expected %h", i, obsWin[i], expWindow(i / WPP, i % WPP));
            end
            nChecks++;
            if (obsIntr[i] !== expI) begin
                nFail++;
                $display("[TB] FAIL steady intr[%0d]: got %b expected %b", i, obsIntr[i], expI);
            end
            if ((i % WPP) != 0) begin
                nChecks++;
                if (obsCyc[i] != obsCyc[i-1] + 1) begin
                    nFail++;
                    $display("[TB] FAIL steady gap[%0d]: got cycle %0d expected %0d", i, obsCyc[i], obsCyc[i-1] + 1);
                end
            end
        end
        if (obsWin.size() >= nExp) begin
            logic [71:0] wl;
            wl = obsWin[nExp-1];
            nChecks++;
            if (wl[71:64] !== 8'h97) begin
                nFail++;
                $display("[TB] FAIL steady last pixel: got %h expected 97", wl[71:64]);
            end
        end
        nChecks++;
        if (maxLinesFull > 4) begin
            nFail++;
            $display("[TB] FAIL lines_full bound: got %0d expected <= 4", maxLinesFull);
        end
        nChecks++;
        if (strayIntr != 0) begin
            nFail++;
            $display("[TB] FAIL steady stray intr: got %0d expected 0", strayIntr);
        end
    endtask

    task automatic test_sparse_valid();
        resetDut();
        applyStimulus(3, 0, 1);
        waitWindows(WPP, 300);
        nChecks++;
        if (obsWin.size() != WPP) begin
            nFail++;
            $display("[TB] FAIL sparse count: got %0d expected %0d", obsWin.size(), WPP);
        end
        if (obsWin.size() >= 1) begin
            nChecks++;
            if (obsCyc[0] != lineEndCyc[2] + 3) begin
                nFail++;
                $display("[TB] FAIL sparse latency: got cycle %0d expected %0d", obsCyc[0], lineEndCyc[2] + 3);
            end
        end
        for (int i = 0; i < WPP && i < obsWin.size(); i++) begin
            logic expI;
            expI = (i == WPP - 1);
            nChecks++;
            if (obsWin[i] !== expWindow(0, i)) begin
                nFail++;
                $display("[TB] FAIL sparse win[%0d]: got %h expected %h", i, obsWin[i], expWindow(0, i));
            end
            nChecks++;
            if (obsIntr[i] !== expI) begin
                nFail++;
                $display("[TB] FAIL sparse intr[%0d]: got %b expected %b", i, obsIntr[i], expI);
            end
        end
    endtask

    task automatic test_mid_read_reset();
        int seen;
        int t;
        resetDut();
        applyStimulus(3, 0, 0);
        seen = 0;
        t = 0;
        while (seen < 3 && t < 100) begin
            @(posedge clk);
            #1;
            if (o_pixel_values_valid) seen++;
            t++;
        end
        nChecks++;
        if (seen != 3) begin
            nFail++;
            $display("[TB] FAIL midReset reach 3rd window: got %0d expected 3", seen);
        end
        rst = 1'b1;
        #1;
        nChecks++;
        if (o_pixel_values_valid !== 1'b0 || o_intr !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL midReset drop: got valid %b intr %b expected 0 0", o_pixel_values_valid, o_intr);
        end
        nChecks++;
        if (o_pixel_values !== 72'h0) begin
            nFail++;
            $display("[TB] FAIL midReset values: got %h expected 0", o_pixel_values);
        end
        resetDut();
        applyStimulus(3, 1, 0);
        waitWindows(WPP, 200);
        nChecks++;
        if (obsWin.size() != WPP) begin
            nFail++;
            $display("[TB] FAIL midReset count: got %0d expected %0d", obsWin.size(), WPP);
        end
        if (obsWin.size() >= 1) begin
            nChecks++;
            if (obsWin[0] !== 72'h82_81_80_82_81_80_82_81_80) begin
                nFail++;
                $display("[TB] FAIL midReset firstWin: got %h expected 828180828180828180", obsWin[0]);
            end
        end
        for (int i = 0; i < WPP && i < obsWin.size(); i++) begin
            nChecks++;
            if (obsWin[i] !== expWindow(0, i)) begin
                nFail++;
                $display("[TB] FAIL midReset win[%0d]: got %h expected %h", i, obsWin[i], expWindow(0, i));
            end
        end
    endtask

    task automatic test_buffer_wrap();
        int nExp;
        resetDut();
        applyStimulus(6, 0, 0);
        nExp = 4 * WPP;
        waitWindows(nExp, 300);
        nChecks++;
        if (obsWin.size() != nExp) begin
            nFail++;
            $display("[TB] FAIL wrap count: got %0d expected %0d", obsWin.size(), nExp);
        end
        if (obsWin.size() > 3 * WPP) begin
            nChecks++;
            if (obsWin[3*WPP] !== 72'h52_51_50_42_41_40_32_31_30) begin
                nFail++;
                $display("[TB] FAIL wrap phase3 first: got %h expected 525150424140323130", obsWin[3*WPP]);
            end
        end
        for (int i = 3 * WPP; i < nExp && i < obsWin.size(); i++) begin
            nChecks++;
            if (obsWin[i] !== expWindow(3, i - 3 * WPP)) begin
                nFail++;
                $display("[TB] FAIL wrap win[%0d]: got %h expected %h", i, obsWin[i], expWindow(3, i - 3 * WPP));
            end
        end
    endtask

    task automatic test_random_stream();
        int nExp;
        resetDut();
        applyStimulus(7, 2, 2);
        nExp = 5 * WPP;
        waitWindows(nExp, 400);
        nChecks++;
        if (obsWin.size() != nExp) begin
            nFail++;
            $display("[TB] FAIL random count: got %0d expected %0d", obsWin.size(), nExp);
        end
        if (obsWin.size() >= 1) begin
            nChecks++;
            if (obsCyc[0] != lineEndCyc[2] + 3) begin
                nFail++;
                $display("[TB] FAIL random latency: got cycle %0d expected %0d", obsCyc[0], lineEndCyc[2] + 3);
            end
        end
        for (int i = 0; i < nExp && i < obsWin.size(); i++) begin
            logic expI;
            expI = ((i % WPP) == WPP - 1);
            nChecks++;
            if (obsWin[i] !== expWindow(i / WPP, i % WPP)) begin
                nFail++;
                $display("[TB] FAIL random win[%0d]: got %h expected %h", i, obsWin[i], expWindow(i / WPP, i % WPP));
            end
            nChecks++;
            if (obsIntr[i] !== expI) begin
                nFail++;
                $display("[TB] FAIL random intr[%0d]: got %b expected %b", i, obsIntr[i], expI);
            end
        end
        nChecks++;
        if (maxLinesFull > 4 || strayIntr != 0) begin
            nFail++;
            $display("[TB] FAIL random invariants: got lines_full max %0d stray intr %0d expected <=4 and 0",
                     maxLinesFull, strayIntr);
        end
    endtask

    // Run the scenarios in order and report once
    initial begin
        test_reset();
        test_first_window();
        test_steady_stream();
        test_sparse_valid();
        test_mid_read_reset();
        test_buffer_wrap();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    // Absolute time limit so a stuck run still terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded limit 500000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
